// File: rtl/mips_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_fetch_unit
// Purpose  : Instruction fetch stage for a single-cycle MIPS core. Holds the
//            PC, fetches one word over a req/ready handshake, presents it to
//            decode and computes the next PC from branch/jump controls.
// Options  : FETCH_PERF_CNT_EN adds retired/taken performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module mips_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        instr_ack,
   input  logic        beq,
   input  logic        bne,
   input  logic        jump,
   input  logic        zero,
   output logic [31:0] pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] retired_cnt,
   output logic [31:0] taken_cnt,
`endif
   output logic [31:0] pc_plus4
);

   // The PC is kept word-aligned by storing only bits [31:2].
   localparam logic [29:0] c_reset_pc_word = RESET_PC[31:2];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_VALID = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [29:0] r_pc_word;
   logic [31:0] r_instr;
   logic        w_load_instr;
   logic        w_load_pc;
   logic        w_taken;
   logic [29:0] w_next_pc_word;

   assign pc        = {r_pc_word, 2'b00};
   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;
   assign instr     = r_instr;
   assign opcode    = r_instr[31:26];

   // Branch resolution: beq/bne both high simply OR their conditions.
   assign w_taken = (beq & zero) | (bne & ~zero);

   // Next-PC selection: jump beats branch, branch beats sequential.
   always_comb begin
      w_next_pc_word = pc_plus4[31:2];
      if (jump) begin
         w_next_pc_word = {pc_plus4[31:28], r_instr[25:0]};
      end else if (w_taken) begin
         w_next_pc_word = pc_plus4[31:2] + {{14{r_instr[15]}}, r_instr[15:0]};
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      imem_req     = 1'b0;
      instr_valid  = 1'b0;
      w_load_instr = 1'b0;
      w_load_pc    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_next = S_REQ;
         end
         S_REQ: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               w_load_instr = 1'b1;
               w_state_next = S_VALID;
            end
         end
         S_VALID: begin
            instr_valid = 1'b1;
            if (instr_ack) begin
               w_load_pc    = 1'b1;
               w_state_next = S_REQ;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Instruction register: captured on the ready cycle of a request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= 32'd0;
      end else if (w_load_instr) begin
         r_instr <= imem_rdata;
      end
   end

   // Program counter: advances only when the core acknowledges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc_word <= c_reset_pc_word;
      end else if (w_load_pc) begin
         r_pc_word <= w_next_pc_word;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Retired and taken-control-transfer counters, wrapping modulo 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= 32'd0;
         taken_cnt   <= 32'd0;
      end else if (w_load_pc) begin
         retired_cnt <= retired_cnt + 32'd1;
         if (jump | w_taken) begin
            taken_cnt <= taken_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mips_fetch_unit
// Purpose  : Directed self-checking bench for mips_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        instr_ack;
   logic        beq;
   logic        bne;
   logic        jump;
   logic        zero;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] retired_cnt;
   logic [31:0] taken_cnt;
   logic [31:0] exp_retired;
   logic [31:0] exp_taken;
`endif

   int n_vec;
   int n_bad;

   mips_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .opcode     (opcode),
      .instr_valid(instr_valid),
      .instr_ack  (instr_ack),
      .beq        (beq),
      .bne        (bne),
      .jump       (jump),
      .zero       (zero),
      .pc         (pc),
`ifdef FETCH_PERF_CNT_EN
      .retired_cnt(retired_cnt),
      .taken_cnt  (taken_cnt),
`endif
      .pc_plus4   (pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Complete a zero-wait fetch of one word (must be in REQ).
   task automatic do_fetch(input logic [31:0] word);
      imem_ready = 1'b1;
      imem_rdata = word;
      step();
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      check_vec("fetch_valid", {31'd0, instr_valid}, 32'd1);
      check_vec("fetch_instr", instr, word);
   endtask

   // Acknowledge the current instruction with the given controls.
   task automatic do_ack(input logic j, input logic b, input logic n, input logic z);
      instr_ack = 1'b1;
      jump = j; beq = b; bne = n; zero = z;
`ifdef FETCH_PERF_CNT_EN
      exp_retired = exp_retired + 32'd1;
      if (j | (b & z) | (n & ~z)) exp_taken = exp_taken + 32'd1;
`endif
      step();
      instr_ack = 1'b0;
      jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
      check_vec("ack_req", {31'd0, imem_req}, 32'd1);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      imem_ready = 1'b0; imem_rdata = 32'd0;
      instr_ack = 1'b0; beq = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      exp_retired = 32'd0;
      exp_taken   = 32'd0;
`endif
      repeat (2) step();

      // Reset state
      check_vec("rst_req",   {31'd0, imem_req}, 32'd0);
      check_vec("rst_valid", {31'd0, instr_valid}, 32'd0);
      check_vec("rst_pc",    pc, 32'd0);
      check_vec("rst_instr", instr, 32'd0);

      // Release: one IDLE cycle, then request
      rst_n = 1'b1;
      #1;
      check_vec("idle_req", {31'd0, imem_req}, 32'd0);
      step();
      check_vec("req_rise",  {31'd0, imem_req}, 32'd1);
      check_vec("req_addr0", imem_addr, 32'h0);
      check_vec("req_novld", {31'd0, instr_valid}, 32'd0);

      // Sequential fetch 0,4,8,12
      do_fetch(32'h2001_0001);
      check_vec("opcode", {26'd0, opcode}, 32'h08);
      do_ack(0, 0, 0, 0);
      check_vec("seq_addr4", imem_addr, 32'h4);
      do_fetch(32'h0000_0020);
      do_ack(0, 0, 0, 0);
      check_vec("seq_addr8", imem_addr, 32'h8);
      do_fetch(32'h0000_0020);
      do_ack(0, 0, 0, 0);
      check_vec("seq_addr12", imem_addr, 32'hC);

      // Wait states (ack during REQ must be ignored)
      for (int i = 0; i < 3; i++) begin
         instr_ack = 1'b1;
         step();
         check_vec("wait_req",   {31'd0, imem_req}, 32'd1);
         check_vec("wait_addr",  imem_addr, 32'hC);
         check_vec("wait_novld", {31'd0, instr_valid}, 32'd0);
      end
      instr_ack = 1'b0;
      do_fetch(32'hAC22_0010);
      check_vec("wait_opcode", {26'd0, opcode}, 32'h2B);
      // Hold in VALID without ack
      jump = 1'b1;
      repeat (2) step();
      jump = 1'b0;
      check_vec("hold_valid", {31'd0, instr_valid}, 32'd1);
      check_vec("hold_pc",    pc, 32'hC);
      check_vec("hold_instr", instr, 32'hAC22_0010);
      do_ack(0, 0, 0, 0);
      check_vec("wait_next", imem_addr, 32'h10);

      // Jump to 0x40, then branch cases
      do_fetch(32'h0800_0010);
      do_ack(1, 0, 0, 0);
      check_vec("jump_0x40", imem_addr, 32'h40);
      do_fetch(32'h1000_FFFE);
      do_ack(0, 1, 0, 1);
      check_vec("beq_taken", imem_addr, 32'h3C);
      do_fetch(32'h0800_0010);
      do_ack(1, 0, 0, 0);
      do_fetch(32'h1000_FFFE);
      do_ack(0, 1, 0, 0);
      check_vec("beq_not", imem_addr, 32'h44);
      do_fetch(32'h0800_0010);
      do_ack(1, 0, 0, 0);
      do_fetch(32'h1400_FFFE);
      do_ack(0, 0, 1, 0);
      check_vec("bne_taken", imem_addr, 32'h3C);

      // Backward branch from 0x3C to 0xFFFF_FFFC, then wrap to 0
      do_fetch(32'h1000_FFEF);
      do_ack(0, 1, 0, 1);
      check_vec("bwd_wrap", imem_addr, 32'hFFFF_FFFC);
      check_vec("pc4_wrap", pc_plus4, 32'h0);
      do_fetch(32'h0000_0020);
      do_ack(0, 0, 0, 0);
      check_vec("seq_wrap", imem_addr, 32'h0);

      // Async reset while VALID at pc=0x20
      do_fetch(32'h0800_0008);
      do_ack(1, 0, 0, 0);
      check_vec("jump_0x20", pc, 32'h20);
      do_fetch(32'h0000_0020);
      #2;
      rst_n = 1'b0;
      #1;
      check_vec("arst_valid", {31'd0, instr_valid}, 32'd0);
      check_vec("arst_req",   {31'd0, imem_req}, 32'd0);
      check_vec("arst_pc",    pc, 32'h0);
      check_vec("arst_instr", instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check_vec("arst_ret", retired_cnt, 32'd0);
      check_vec("arst_tkn", taken_cnt, 32'd0);
      exp_retired = 32'd0;
      exp_taken   = 32'd0;
`endif
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      rst_n = 1'b1;
      step();
      check_vec("restart_req",  {31'd0, imem_req}, 32'd1);
      check_vec("restart_addr", imem_addr, 32'h0);

      // Climb to 0x1000_0010 with 2048 max forward branches from 0x10
      do_fetch(32'h0800_0004);
      do_ack(1, 0, 0, 0);
      check_vec("jump_0x10", pc, 32'h10);
      for (int k = 0; k < 2048; k++) begin
         imem_ready = 1'b1;
         imem_rdata = 32'h1000_7FFF;
         step();
         imem_ready = 1'b0;
         instr_ack = 1'b1; beq = 1'b1; zero = 1'b1;
         step();
         instr_ack = 1'b0; beq = 1'b0; zero = 1'b0;
`ifdef FETCH_PERF_CNT_EN
         exp_retired = exp_retired + 32'd1;
         exp_taken   = exp_taken + 32'd1;
`endif
      end
      check_vec("climb_pc", pc, 32'h1000_0010);

      // Jump beats a taken beq
      do_fetch(32'h0800_0100);
      do_ack(1, 1, 0, 1);
      check_vec("jump_prio", imem_addr, 32'h1000_0400);
`ifdef FETCH_PERF_CNT_EN
      check_vec("cnt_ret", retired_cnt, exp_retired);
      check_vec("cnt_tkn", taken_cnt, exp_taken);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
